// File: rtl/sobel_pkg.sv
// Shared types for the Sobel pipeline: default pixel width, pixel type and the
// window-generator FSM states. Imported by the window generator and gradient blocks.
package sobel_pkg;

   localparam int PIX_W_DEF = 8;

   typedef logic [PIX_W_DEF-1:0] pixel_t;

   typedef enum logic [1:0] {IDLE, FILL, ACTIVE} win_state_t;

endpackage

// File: rtl/sobel_line_buffer.sv
// One image line of pixel storage: single clock, single address, asynchronous read
// so the old word is visible in the same cycle it is overwritten.
module sobel_line_buffer
   import sobel_pkg::*;
#(
   parameter int DEPTH = 640,
   parameter int WIDTH = PIX_W_DEF
) (
   input  logic                     clk,
   input  logic                     we,
   input  logic [$clog2(DEPTH)-1:0] addr,
   input  logic [WIDTH-1:0]         wdata,
   output logic [WIDTH-1:0]         rdata
);

   logic [WIDTH-1:0] mem [DEPTH];

   assign rdata = mem[addr];

   // NOTE: storage arrays carry no reset; every entry is rewritten before it is used.
   always_ff @(posedge clk) begin
      if (we) mem[addr] <= wdata;
   end

endmodule

// File: rtl/sobel_window_gen.sv
// Raster-stream 3x3 window generator feeding the Sobel gradient units.
// Define SOBEL_FRAME_DONE_EN to add the frame_done pulse on the last window of a frame.
module sobel_window_gen
   import sobel_pkg::*;
#(
   parameter int IMG_WIDTH  = 640,
   parameter int IMG_HEIGHT = 480,
   parameter int PIX_W      = PIX_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             sof,
   input  logic [PIX_W-1:0] pix_in,
   input  logic             pix_valid,
   output logic [PIX_W-1:0] P0,
   output logic [PIX_W-1:0] P1,
   output logic [PIX_W-1:0] P2,
   output logic [PIX_W-1:0] P3,
   output logic [PIX_W-1:0] P4,
   output logic [PIX_W-1:0] P5,
   output logic [PIX_W-1:0] P6,
   output logic [PIX_W-1:0] P7,
   output logic [PIX_W-1:0] P8,
   output logic             start_calculations
`ifdef SOBEL_FRAME_DONE_EN
   ,
   output logic             frame_done
`endif
);

   localparam int CW = $clog2(IMG_WIDTH);
   localparam int RW = $clog2(IMG_HEIGHT);
   localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
   localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);
   localparam logic [CW-1:0] COL_WIN  = CW'(2);
   localparam logic [RW-1:0] ROW_WIN  = RW'(2);

   win_state_t       state;
   logic [CW-1:0]    col;
   logic [RW-1:0]    row;
   logic [CW-1:0]    addr;
   logic             restart, take, at_eol, at_eof, win_hit;
   logic [PIX_W-1:0] lb1_rd, lb2_rd;
   logic [PIX_W-1:0] l_top, l_mid, l_bot, m_top, m_mid, m_bot;

   // NOTE: pure decode with every output assigned on every pass, so no latches form.
   always_comb begin
      restart = pix_valid & sof;
      take    = pix_valid & (sof | (state != IDLE));
      addr    = restart ? '0 : col;
      at_eol  = (col == COL_LAST);
      at_eof  = at_eol & (row == ROW_LAST);
      win_hit = pix_valid & ~sof & (state != IDLE) & (row >= ROW_WIN) & (col >= COL_WIN);
   end

   sobel_line_buffer #(.DEPTH(IMG_WIDTH), .WIDTH(PIX_W)) u_lb1 (
      .clk   (clk),
      .we    (take),
      .addr  (addr),
      .wdata (pix_in),
      .rdata (lb1_rd)
   );

   sobel_line_buffer #(.DEPTH(IMG_WIDTH), .WIDTH(PIX_W)) u_lb2 (
      .clk   (clk),
      .we    (take),
      .addr  (addr),
      .wdata (lb1_rd),
      .rdata (lb2_rd)
   );

   // A sof pixel always restarts the frame at (0,0), whichever state we were in.
   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         col   <= '0;
         row   <= '0;
      end else if (restart) begin
         state <= FILL;
         col   <= CW'(1);
         row   <= '0;
      end else if (take) begin
         if (at_eol) begin
            col <= '0;
            row <= at_eof ? '0 : row + RW'(1);
         end else begin
            col <= col + CW'(1);
         end
         case (state)
            FILL:    if (at_eol && row == RW'(1)) state <= ACTIVE;
            ACTIVE:  if (at_eof) state <= IDLE;
            default: state <= state;
         endcase
      end
   end

   // Two history columns; at column 0 both collapse onto the new column so no
   // pixels from the previous line leak into the first windows of a row.
   always_ff @(posedge clk) begin
      if (take) begin
         if (addr == '0) begin
            {l_top, l_mid, l_bot} <= {lb2_rd, lb1_rd, pix_in};
         end else begin
            {l_top, l_mid, l_bot} <= {m_top, m_mid, m_bot};
         end
         {m_top, m_mid, m_bot} <= {lb2_rd, lb1_rd, pix_in};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         {P0, P1, P2, P3, P4, P5, P6, P7, P8} <= '0;
         start_calculations                   <= 1'b0;
      end else begin
         start_calculations <= win_hit;
         if (win_hit) begin
            {P0, P1, P2} <= {l_top, m_top, lb2_rd};
            {P3, P4, P5} <= {l_mid, m_mid, lb1_rd};
            {P6, P7, P8} <= {l_bot, m_bot, pix_in};
         end
      end
   end

`ifdef SOBEL_FRAME_DONE_EN
   always_ff @(posedge clk) begin
      if (rst) frame_done <= 1'b0;
      else     frame_done <= win_hit & at_eof;
   end
`endif

endmodule

// File: tb/tb_sobel_window_gen.sv
// Self-checking bench for sobel_window_gen on a 4x4 image: image-array reference model
// compared every cycle, plus literal window expectations for the directed scenarios.
module tb_sobel_window_gen;
   import sobel_pkg::*;

   localparam int W = 4;
   localparam int H = 4;

   logic   clk = 1'b0;
   logic   rst, sof, pix_valid;
   pixel_t pix_in;
   pixel_t P [9];
   logic   start_calculations;
`ifdef SOBEL_FRAME_DONE_EN
   logic   frame_done;
`endif

   int n_cmp = 0;
   int n_bad = 0;

   logic [71:0] wins [$];
   int          fds  [$];

   always #5 clk = ~clk;

   sobel_window_gen #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .PIX_W(8)) dut (
      .clk                (clk),
      .rst                (rst),
      .sof                (sof),
      .pix_in             (pix_in),
      .pix_valid          (pix_valid),
      .P0                 (P[0]),
      .P1                 (P[1]),
      .P2                 (P[2]),
      .P3                 (P[3]),
      .P4                 (P[4]),
      .P5                 (P[5]),
      .P6                 (P[6]),
      .P7                 (P[7]),
      .P8                 (P[8]),
      .start_calculations (start_calculations)
`ifdef SOBEL_FRAME_DONE_EN
      ,
      .frame_done         (frame_done)
`endif
   );

   // Reference model: remember every accepted pixel of the current frame by position
   // and cut the 3x3 neighbourhood directly out of that image.
   pixel_t      img [H][W];
   int          m_r = 0, m_c = 0;
   bit          m_live = 1'b0;
   logic [71:0] exp_win = '0;
   bit          exp_stb = 1'b0, exp_fd = 1'b0;

   always @(posedge clk) begin
      exp_stb = 1'b0;
      exp_fd  = 1'b0;
      if (rst) begin
         m_live  = 1'b0;
         m_r     = 0;
         m_c     = 0;
         exp_win = '0;
      end else if (pix_valid && (sof || m_live)) begin
         if (sof) begin
            m_live = 1'b1;
            m_r    = 0;
            m_c    = 0;
         end
         img[m_r][m_c] = pix_in;
         if (m_r >= 2 && m_c >= 2) begin
            for (int i = 0; i < 3; i++)
               for (int j = 0; j < 3; j++)
                  exp_win[71 - 8*(3*i + j) -: 8] = img[m_r - 2 + i][m_c - 2 + j];
            exp_stb = 1'b1;
            exp_fd  = (m_r == H - 1) && (m_c == W - 1);
         end
         m_c = m_c + 1;
         if (m_c == W) begin
            m_c = 0;
            m_r = m_r + 1;
            if (m_r == H) begin
               m_r    = 0;
               m_live = 1'b0;
            end
         end
      end
   end

   task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
      end
   endtask

   function automatic logic [71:0] window_now();
      return {P[0], P[1], P[2], P[3], P[4], P[5], P[6], P[7], P[8]};
   endfunction

   task automatic compare();
      logic [71:0] got;
      got = window_now();
      check("strobe", 72'(start_calculations), 72'(exp_stb));
      check("window", got, exp_win);
`ifdef SOBEL_FRAME_DONE_EN
      check("frame_done", 72'(frame_done), 72'(exp_fd));
      if (frame_done) fds.push_back(wins.size() + 1);
`endif
      if (start_calculations) wins.push_back(got);
   endtask

   // One clock: drive at the falling edge, let the rising edge take it, compare at the next fall.
   task automatic step(input logic v, input logic s, input pixel_t p, input logic r);
      rst       = r;
      pix_valid = v;
      sof       = s;
      pix_in    = p;
      @(posedge clk);
      @(negedge clk);
      compare();
   endtask

   task automatic send_frame(input int base, input int n_pix, input bit stall);
      for (int k = 0; k < n_pix; k++) begin
         step(1'b1, k == 0, pixel_t'(base + (k / W) * 16 + (k % W)), 1'b0);
         if (stall) begin
            step(1'b0, 1'b0, pixel_t'($urandom), 1'b0);
            step(1'b0, 1'b0, pixel_t'($urandom), 1'b0);
         end
      end
   endtask

   initial begin
      int mark, fmark;
      rst = 1'b1; sof = 1'b0; pix_valid = 1'b0; pix_in = '0;
      step(1'b0, 1'b0, 8'h00, 1'b1);
      step(1'b0, 1'b0, 8'h00, 1'b1);
      check("reset_window", window_now(), '0);
      check("reset_strobe", 72'(start_calculations), '0);

      // Full frame, continuous stream; also covers the line-wrap window.
      mark = wins.size(); fmark = fds.size();
      send_frame(0, 16, 1'b0);
      check("s1_count", 72'(wins.size() - mark), 72'd4);
      check("s1_first", wins[mark], 72'h00_01_02_10_11_12_20_21_22);
      check("s3_wrap", wins[mark + 2], 72'h10_11_12_20_21_22_30_31_32);
      check("s1_last_p8", 72'(wins[mark + 3][7:0]), 72'h33);
`ifdef SOBEL_FRAME_DONE_EN
      check("s6_fd_count", 72'(fds.size() - fmark), 72'd1);
      check("s6_fd_on_4th", 72'(fds[fmark]), 72'(mark + 4));
`endif

      // Same frame with 1,0,0 valid pattern.
      mark = wins.size();
      send_frame(0, 16, 1'b1);
      check("s2_count", 72'(wins.size() - mark), 72'd4);
      check("s2_first", wins[mark], 72'h00_01_02_10_11_12_20_21_22);
      check("s2_last", wins[mark + 3], 72'h11_12_13_21_22_23_31_32_33);

      // Abort after pixel 0x21, then a fresh frame.
      mark = wins.size(); fmark = fds.size();
      send_frame(0, 10, 1'b0);
      check("s4_abort_count", 72'(wins.size() - mark), 72'd0);
`ifdef SOBEL_FRAME_DONE_EN
      check("s6_abort_fd", 72'(fds.size() - fmark), 72'd0);
`endif
      send_frame(8'h80, 16, 1'b0);
      check("s4_count", 72'(wins.size() - mark), 72'd4);
      check("s4_first", wins[mark], 72'h80_81_82_90_91_92_a0_a1_a2);

      // sof arriving in place of the last pixel wins over frame completion.
      mark = wins.size(); fmark = fds.size();
      send_frame(0, 15, 1'b0);
      check("sof_last_count", 72'(wins.size() - mark), 72'd3);
`ifdef SOBEL_FRAME_DONE_EN
      check("sof_last_fd", 72'(fds.size() - fmark), 72'd0);
`endif
      send_frame(8'h40, 16, 1'b0);
      check("sof_last_new", 72'(wins.size() - mark), 72'd7);

      // Reset mid row 2, then sof-less pixels must be ignored.
      send_frame(0, 10, 1'b0);
      step(1'b1, 1'b0, 8'h22, 1'b1);
      check("s5_window", window_now(), '0);
      check("s5_strobe", 72'(start_calculations), '0);
      mark = wins.size();
      for (int k = 0; k < 16; k++) step(1'b1, 1'b0, pixel_t'($urandom), 1'b0);
      check("s5_ignored", 72'(wins.size() - mark), 72'd0);
      send_frame(8'h10, 16, 1'b0);
      check("s5_resume", 72'(wins.size() - mark), 72'd4);

      // Random traffic: stalls, stray pixels, aborts and occasional resets.
      for (int k = 0; k < 800; k++) begin
         logic v, s, r;
         v = ($urandom_range(0, 3) != 0);
         s = v && ($urandom_range(0, 19) == 0);
         r = ($urandom_range(0, 149) == 0);
         step(v, s, pixel_t'($urandom), r);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
